wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-side consumer of the functional-unit writeback handshake (valid/ready, pdest, wdata, rob_idx, we) driven by the ALU/other FU pipes.
- Arbitrates NUM_IN FU writeback streams onto NUM_WP physical-regfile write ports with round-robin fairness.
- Registers the winners for one cycle and drives regfile writes, ROB completion and wakeup.
- Sits between the integer-block FU pipes and the regfile/ROB.

Parameters:
- NUM_IN, 4, number of FU writeback inputs (>=2)
- NUM_WP, 2, number of regfile write ports (1..NUM_IN)
- XLEN, 32, data width
- PREG_W, 6, physical register index width
- ROB_W, 6, ROB index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; blocks grants this cycle
- wb_valid_i  in  NUM_IN  per-input writeback valid
- wb_we_i  in  NUM_IN  per-input regfile write enable
- wb_pdest_i  in  NUM_IN*PREG_W  per-input destination preg, input i at [i*PREG_W +: PREG_W]
- wb_wdata_i  in  NUM_IN*XLEN  per-input write data
- wb_rob_idx_i  in  NUM_IN*ROB_W  per-input ROB index
- wb_ready_o  out  NUM_IN  per-input grant/accept
- rf_we_o  out  NUM_WP  regfile write enable per port (also wakeup valid)
- rf_waddr_o  out  NUM_WP*PREG_W  regfile write address
- rf_wdata_o  out  NUM_WP*XLEN  regfile write data
- cmpl_valid_o  out  NUM_WP  ROB completion valid
- cmpl_rob_idx_o  out  NUM_WP*ROB_W  ROB index completed
- conflict_cnt_o  out  32  saturating count of oversubscribed cycles

Behaviour:
- Reset (async): all outputs 0; rr_ptr = 0; conflict_cnt = 0. Reset mid-transfer discards registered winners; no completion is emitted for them.
- Handshake: input i transfers in cycle t iff wb_valid_i[i] & wb_ready_o[i].
  - wb_ready_o is combinational from wb_valid_i, rr_ptr and flush_i.
  - wb_ready_o[i] = 0 whenever wb_valid_i[i] = 0.
  - Upstream holds payload stable while valid & ~ready.
- Selection: scan indices rr_ptr, rr_ptr+1, ... mod NUM_IN; the first NUM_WP valid inputs are granted.
  - The k-th granted input in scan order goes to output slot k. Unused slots are empty.
- Downstream never stalls; output stage accepts every cycle.
- Latency: exactly 1 cycle. Input granted at t appears on slot k at t+1 for one cycle only.
  - At t+1: cmpl_valid_o[k] = 1, cmpl_rob_idx_o = rob_idx, rf_waddr_o = pdest, rf_wdata_o = wdata, rf_we_o[k] = we.
  - Empty slot: cmpl_valid_o = rf_we_o = 0; addr/data/idx = 0.
- we = 0 input: granted normally, consumes a slot, completes the ROB entry, rf_we_o = 0.
- rr_ptr update:
  - If any grant: rr_ptr <= (index of last granted input + 1) mod NUM_IN, wrapping NUM_IN-1 -> 0.
  - If no grant: unchanged.
  - Guarantees every persistently valid input is granted within ceil(NUM_IN/NUM_WP) cycles.
- flush_i = 1 at t:
  - all wb_ready_o = 0; no grants; rr_ptr unchanged; conflict_cnt unchanged.
  - Output registers load empty at t+1.
  - Entries already registered at t still emit at t (flush does not retract the current output).
- conflict_cnt: +1 in each non-flush cycle where popcount(wb_valid_i) > NUM_WP; saturates at 0xFFFF_FFFF.
- Fewer valid inputs than NUM_WP: all granted the same cycle; remaining slots empty.
- Duplicate pdest on two inputs in the same cycle is an upstream error; both are passed through without checking.

Decomposition:
- Shared package gets:
  - wb_in_t struct {we, pdest, wdata, rob_idx}
  - wb_out_t struct {valid, we, pdest, wdata, rob_idx}
  - localparams WB_NUM_IN, WB_NUM_WP
- Sub-module wb_rr_select: purely combinational.
  - Inputs: valid vector, rr_ptr.
  - Outputs: grant vector, per-slot one-hot select, per-slot slot_valid, next_ptr.
  - Parameterised by NUM_IN/NUM_WP.
- Top holds the output registers, rr_ptr, conflict counter and flush gating.

Test Plan:
- Reset, then valid=4'b0001, pdest=5, wdata=0xDEAD_BEEF, rob=3, we=1 -> ready=0001 same cycle; next cycle slot0: rf_we=1, waddr=5, wdata=0xDEADBEEF, cmpl_idx=3; slot1 empty; rr_ptr=1.
- valid=4'b1111 held 3 cycles from rr_ptr=0 -> grants 0011, 1100, 0011; rr_ptr 0->2->0->2; conflict_cnt=3.
- rr_ptr=3, valid=4'b1001 -> input3 to slot0, input0 to slot1 (wrap); rr_ptr becomes 1.
- valid=4'b0100 with we=0, rob=9 -> next cycle cmpl_valid[0]=1, cmpl_rob_idx=9, rf_we[0]=0.
- valid=4'b0011 with flush_i=1 -> ready=0000, next cycle all outputs 0, rr_ptr unchanged; flush deasserted -> both granted the following cycle.
- Grant input 2 at t, assert rst_n=0 mid-cycle t+1 -> outputs drop to 0 immediately; no completion after reset release; conflict_cnt=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and default sizing for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int unsigned WB_NUM_IN  = 4;
    localparam int unsigned WB_NUM_WP  = 2;
    localparam int unsigned WB_XLEN    = 32;
    localparam int unsigned WB_PREG_W  = 6;
    localparam int unsigned WB_ROB_W   = 6;

    typedef struct packed {
        logic                 we;
        logic [WB_PREG_W-1:0] pdest;
        logic [WB_XLEN-1:0]   wdata;
        logic [WB_ROB_W-1:0]  rob_idx;
    } wb_in_t;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [WB_PREG_W-1:0] pdest;
        logic [WB_XLEN-1:0]   wdata;
        logic [WB_ROB_W-1:0]  rob_idx;
    } wb_out_t;

endpackage

// File: rtl/wb_arbiter_rr_select.sv
// Combinational round-robin picker: grants the first NUM_WP valid inputs
// scanning upward from ptr_i, and reports the pointer after the last grant.
module wb_rr_select #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned NUM_WP = 2,
    parameter int unsigned PTR_W  = $clog2(NUM_IN),
    parameter int unsigned SLOT_W = (NUM_WP > 1) ? $clog2(NUM_WP) : 1
) (
    input  logic [NUM_IN-1:0]             valid_i,
    input  logic [PTR_W-1:0]              ptr_i,
    output logic [NUM_IN-1:0]             grant_o,
    output logic [NUM_WP-1:0][NUM_IN-1:0] sel_o,
    output logic [NUM_WP-1:0]             slot_valid_o,
    output logic [PTR_W-1:0]              next_ptr_o
);

    always_comb begin
        int unsigned cnt;
        int unsigned idx;
        int unsigned last;
        grant_o      = '0;
        sel_o        = '0;
        slot_valid_o = '0;
        next_ptr_o   = ptr_i;
        cnt          = 0;
        idx          = 0;
        last         = 0;
        for (int unsigned off = 0; off < NUM_IN; off++) begin
            idx = ptr_i + off;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (valid_i[PTR_W'(idx)] && cnt < NUM_WP) begin
                grant_o[PTR_W'(idx)]                   = 1'b1;
                sel_o[SLOT_W'(cnt)][PTR_W'(idx)]       = 1'b1;
                slot_valid_o[SLOT_W'(cnt)]             = 1'b1;
                last                                   = idx;
                cnt                                    = cnt + 1;
            end
        end
        if (cnt != 0) begin
            next_ptr_o = (last + 1 == NUM_IN) ? '0 : PTR_W'(last + 1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin merge of NUM_IN FU writeback streams onto
// NUM_WP regfile write ports, registered for one cycle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IN = WB_NUM_IN,
    parameter int unsigned NUM_WP = WB_NUM_WP,
    parameter int unsigned XLEN   = WB_XLEN,
    parameter int unsigned PREG_W = WB_PREG_W,
    parameter int unsigned ROB_W  = WB_ROB_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [NUM_IN-1:0]        wb_valid_i,
    input  logic [NUM_IN-1:0]        wb_we_i,
    input  logic [NUM_IN*PREG_W-1:0] wb_pdest_i,
    input  logic [NUM_IN*XLEN-1:0]   wb_wdata_i,
    input  logic [NUM_IN*ROB_W-1:0]  wb_rob_idx_i,
    output logic [NUM_IN-1:0]        wb_ready_o,
    output logic [NUM_WP-1:0]        rf_we_o,
    output logic [NUM_WP*PREG_W-1:0] rf_waddr_o,
    output logic [NUM_WP*XLEN-1:0]   rf_wdata_o,
    output logic [NUM_WP-1:0]        cmpl_valid_o,
    output logic [NUM_WP*ROB_W-1:0]  cmpl_rob_idx_o,
    output logic [31:0]              conflict_cnt_o
);

    localparam int unsigned PTR_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W = $clog2(NUM_IN + 1);

    wb_in_t                     in_s [NUM_IN];
    wb_out_t                    out_d [NUM_WP];
    wb_out_t                    out_q [NUM_WP];
    logic [PTR_W-1:0]           rr_ptr_d, rr_ptr_q;
    logic [31:0]                conflict_cnt_d, conflict_cnt_q;
    logic [NUM_IN-1:0]          grant;
    logic [NUM_WP-1:0][NUM_IN-1:0] sel;
    logic [NUM_WP-1:0]          slot_valid;
    logic [PTR_W-1:0]           next_ptr;
    logic [CNT_W-1:0]           n_valid;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            in_s[i].we      = wb_we_i[i];
            in_s[i].pdest   = wb_pdest_i[i*PREG_W +: PREG_W];
            in_s[i].wdata   = wb_wdata_i[i*XLEN +: XLEN];
            in_s[i].rob_idx = wb_rob_idx_i[i*ROB_W +: ROB_W];
        end
    end

    wb_rr_select #(
        .NUM_IN (NUM_IN),
        .NUM_WP (NUM_WP)
    ) u_select (
        .valid_i      (wb_valid_i),
        .ptr_i        (rr_ptr_q),
        .grant_o      (grant),
        .sel_o        (sel),
        .slot_valid_o (slot_valid),
        .next_ptr_o   (next_ptr)
    );

    assign wb_ready_o = flush_i ? '0 : grant;

    always_comb begin
        for (int unsigned k = 0; k < NUM_WP; k++) begin
            out_d[k] = '0;
            if (!flush_i && slot_valid[k]) begin
                out_d[k].valid = 1'b1;
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    if (sel[k][i]) begin
                        out_d[k].we      = in_s[i].we;
                        out_d[k].pdest   = in_s[i].pdest;
                        out_d[k].wdata   = in_s[i].wdata;
                        out_d[k].rob_idx = in_s[i].rob_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        n_valid = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            n_valid = n_valid + CNT_W'(wb_valid_i[i]);
        end
        rr_ptr_d       = flush_i ? rr_ptr_q : next_ptr;
        conflict_cnt_d = conflict_cnt_q;
        // Saturate rather than wrap so long runs still read as "heavily contended".
        if (!flush_i && n_valid > CNT_W'(NUM_WP) && conflict_cnt_q != '1) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            conflict_cnt_q <= '0;
            for (int unsigned k = 0; k < NUM_WP; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
            for (int unsigned k = 0; k < NUM_WP; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_WP; k++) begin
            rf_we_o[k]                       = out_q[k].valid & out_q[k].we;
            cmpl_valid_o[k]                  = out_q[k].valid;
            rf_waddr_o[k*PREG_W +: PREG_W]   = out_q[k].pdest;
            rf_wdata_o[k*XLEN +: XLEN]       = out_q[k].wdata;
            cmpl_rob_idx_o[k*ROB_W +: ROB_W] = out_q[k].rob_idx;
        end
        conflict_cnt_o = conflict_cnt_q;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table plus hand sequences,
// with registered outputs checked through a one-deep scoreboard queue.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  wb_valid_i = '0;
    logic [3:0]  wb_we_i = '0;
    logic [23:0] wb_pdest_i = '0;
    logic [127:0] wb_wdata_i = '0;
    logic [23:0] wb_rob_idx_i = '0;
    logic [3:0]  wb_ready_o;
    logic [1:0]  rf_we_o;
    logic [11:0] rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic [1:0]  cmpl_valid_o;
    logic [11:0] cmpl_rob_idx_o;
    logic [31:0] conflict_cnt_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_IN (4),
        .NUM_WP (2),
        .XLEN   (32),
        .PREG_W (6),
        .ROB_W  (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .wb_valid_i     (wb_valid_i),
        .wb_we_i        (wb_we_i),
        .wb_pdest_i     (wb_pdest_i),
        .wb_wdata_i     (wb_wdata_i),
        .wb_rob_idx_i   (wb_rob_idx_i),
        .wb_ready_o     (wb_ready_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .cmpl_valid_o   (cmpl_valid_o),
        .cmpl_rob_idx_o (cmpl_rob_idx_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    typedef struct {
        logic       flush;
        logic [3:0] valid;
        logic [3:0] we;
        logic [3:0] ready;
        int         s0;
        int         s1;
        logic [31:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [1:0]  cv;
        logic [1:0]  rfwe;
        logic [11:0] addr;
        logic [63:0] data;
        logic [11:0] rob;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[13];
    logic [5:0]  pd[4];
    logic [31:0] wd[4];
    logic [5:0]  rb[4];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fill_payload(input int n);
        for (int i = 0; i < 4; i++) begin
            pd[i] = 6'(n * 4 + i + 1);
            wd[i] = 32'hA500_0000 + 32'(n * 256 + i);
            rb[i] = 6'(n * 3 + i + 2);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("cmpl_valid", 64'(cmpl_valid_o), 64'(e.cv));
            chk("rf_we", 64'(rf_we_o), 64'(e.rfwe));
            chk("rf_waddr", 64'(rf_waddr_o), 64'(e.addr));
            chk("rf_wdata", rf_wdata_o, e.data);
            chk("cmpl_rob_idx", 64'(cmpl_rob_idx_o), 64'(e.rob));
            chk("conflict_cnt", 64'(conflict_cnt_o), 64'(e.cnt));
        end
    endtask

    task automatic push_empty(input logic [31:0] cnt);
        exp_t e;
        e = '0;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic fl, input logic [3:0] v, input logic [3:0] w,
                         input logic [3:0] rdy, input int s0, input int s1,
                         input logic [31:0] cnt);
        exp_t e;
        int   s[2];
        @(negedge clk);
        flush_i    = fl;
        wb_valid_i = v;
        wb_we_i    = w;
        for (int i = 0; i < 4; i++) begin
            wb_pdest_i[i*6 +: 6]    = pd[i];
            wb_wdata_i[i*32 +: 32]  = wd[i];
            wb_rob_idx_i[i*6 +: 6]  = rb[i];
        end
        #1;
        chk("wb_ready", 64'(wb_ready_o), 64'(rdy));
        compare_out();
        s[0] = s0;
        s[1] = s1;
        e = '0;
        e.cnt = cnt;
        for (int k = 0; k < 2; k++) begin
            if (s[k] >= 0) begin
                e.cv[k]            = 1'b1;
                e.rfwe[k]          = w[s[k]];
                e.addr[k*6 +: 6]   = pd[s[k]];
                e.data[k*32 +: 32] = wd[s[k]];
                e.rob[k*6 +: 6]    = rb[s[k]];
            end
        end
        sb.push_back(e);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cmpl_valid"}, 64'(cmpl_valid_o), 64'd0);
        chk({tag, "_rf_we"}, 64'(rf_we_o), 64'd0);
        chk({tag, "_rf_waddr"}, 64'(rf_waddr_o), 64'd0);
        chk({tag, "_rf_wdata"}, rf_wdata_o, 64'd0);
        chk({tag, "_rob_idx"}, 64'(cmpl_rob_idx_o), 64'd0);
        chk({tag, "_conflict_cnt"}, 64'(conflict_cnt_o), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        flush_i    = 1'b0;
        wb_valid_i = '0;
        wb_we_i    = '0;
        #1;
        chk_zero_outputs("reset");
        chk("reset_ready", 64'(wb_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        push_empty(32'd0);
    endtask

    initial begin
        //          flush valid    we       ready    s0  s1  cnt
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 0};
        tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001,  0, -1, 0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0110,  1,  2, 1};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1010, 4'b1001,  3,  0, 2};
        tbl[4]  = '{1'b0, 4'b0101, 4'b0101, 4'b0101,  2,  0, 2};
        tbl[5]  = '{1'b1, 4'b0011, 4'b0011, 4'b0000, -1, -1, 2};
        tbl[6]  = '{1'b0, 4'b0011, 4'b0011, 4'b0011,  1,  0, 2};
        tbl[7]  = '{1'b0, 4'b1110, 4'b0110, 4'b0110,  1,  2, 3};
        tbl[8]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000,  3, -1, 3};
        tbl[9]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, -1, -1, 3};
        tbl[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0011,  0,  1, 4};
        tbl[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0100,  2, -1, 4};
        tbl[12] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 4};

        fill_payload(0);
        do_reset();

        // Single write from reset state.
        pd[0] = 6'd5;
        wd[0] = 32'hDEAD_BEEF;
        rb[0] = 6'd3;
        cycle(1'b0, 4'b0001, 4'b0001, 4'b0001, 0, -1, 0);
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 0);

        do_reset();
        for (int n = 0; n < 13; n++) begin
            fill_payload(n + 1);
            cycle(tbl[n].flush, tbl[n].valid, tbl[n].we, tbl[n].ready,
                  tbl[n].s0, tbl[n].s1, tbl[n].cnt);
        end
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 4);

        // All inputs valid for three cycles, then pointer wrap, then we=0.
        do_reset();
        fill_payload(20);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0011, 0, 1, 1);
        fill_payload(21);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b1100, 2, 3, 2);
        fill_payload(22);
        cycle(1'b0, 4'b1111, 4'b1111, 4'b0011, 0, 1, 3);
        fill_payload(23);
        cycle(1'b0, 4'b0100, 4'b0100, 4'b0100, 2, -1, 3);
        fill_payload(24);
        cycle(1'b0, 4'b1001, 4'b1001, 4'b1001, 3, 0, 3);
        fill_payload(25);
        cycle(1'b0, 4'b0011, 4'b0011, 4'b0011, 1, 0, 3);
        fill_payload(26);
        rb[2] = 6'd9;
        cycle(1'b0, 4'b0100, 4'b0000, 4'b0100, 2, -1, 3);

        // Reset while a granted entry is sitting in the output registers.
        fill_payload(27);
        cycle(1'b0, 4'b0100, 4'b0100, 4'b0100, 2, -1, 3);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        wb_valid_i = '0;
        #1;
        chk_zero_outputs("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_empty(32'd0);
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 0);
        cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, -1, -1, 0);
        @(negedge clk);
        #1;
        compare_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
